dac_wave_gen: RTL and testbench

Periodic waveform source for the 5-bit resistor-ladder DAC output stage. A phase accumulator with a selectable shape map (sawtooth, triangle, square, sine LUT) produces a registered 5-bit code that drives the DAC pins bit4..bit0 directly. Frequency and shape are reconfigured through a valid/ready port. A new configuration takes effect only at a phase wrap, so the output waveform has no mid-period discontinuities.

---
 rtl/dac_wave_gen.sv | 90 +++++++++
 tb/tb_dac_wave_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dac_wave_gen.sv
// dac_wave_gen: phase-accumulator waveform source for a 5-bit ladder DAC with wrap-aligned reconfiguration
module dac_wave_gen #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [ACC_W-1:0] cfg_ftw,
    output logic [4:0]       dac_code,
    output logic             wrap
);
    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    localparam logic [4:0] SINE [32] = '{
        5'd16, 5'd19, 5'd21, 5'd24, 5'd26, 5'd28, 5'd30, 5'd31,
        5'd31, 5'd31, 5'd30, 5'd28, 5'd26, 5'd24, 5'd21, 5'd19,
        5'd16, 5'd12, 5'd10, 5'd7,  5'd5,  5'd3,  5'd1,  5'd0,
        5'd0,  5'd0,  5'd1,  5'd3,  5'd5,  5'd7,  5'd10, 5'd12
    };

    state_t           state, state_nx;
    logic [ACC_W-1:0] acc, ftw, sh_ftw;
    logic [1:0]       mode, sh_mode;
    logic [ACC_W:0]   sum;
    logic             hs, carry;
    logic [4:0]       p, shape;
    logic [5:0]       t;

    // Reset holds the port closed; otherwise only a pending shadow blocks new offers.
    assign cfg_ready = !rst && state != PEND;

    // Next phase, shape lookup of the current phase, and state transitions.
    always_comb begin
        sum      = {1'b0, acc} + {1'b0, ftw};
        carry    = sum[ACC_W];
        hs       = cfg_valid && cfg_ready;
        p        = acc[ACC_W-1 -: 5];
        t        = acc[ACC_W-1 -: 6];
        shape    = mode == 2'd0 ? p :
                   mode == 2'd1 ? (t[5] ? ~t[4:0] : t[4:0]) :
                   mode == 2'd2 ? {5{acc[ACC_W-1]}} : SINE[p];
        state_nx = state == IDLE ? (en ? RUN : IDLE) :
                   !en           ? IDLE :
                   state == RUN  ? (hs ? PEND : RUN) :
                   carry         ? RUN : PEND;
    end

    // Accumulator, active/shadow config and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            ftw      <= '0;
            mode     <= '0;
            sh_ftw   <= '0;
            sh_mode  <= '0;
            dac_code <= '0;
            wrap     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE || !en) begin
                acc      <= '0;
                dac_code <= '0;
                wrap     <= 1'b0;
                if (state == PEND) begin
                    mode <= sh_mode;
                    ftw  <= sh_ftw;
                end else if (hs) begin
                    mode <= cfg_mode;
                    ftw  <= cfg_ftw;
                end
            end else begin
                acc      <= sum[ACC_W-1:0];
                wrap     <= carry;
                dac_code <= shape;
                if (state == PEND && carry) begin
                    mode <= sh_mode;
                    ftw  <= sh_ftw;
                end
                if (state == RUN && hs) begin
                    sh_mode <= cfg_mode;
                    sh_ftw  <= cfg_ftw;
                end
            end
        end
    end
endmodule

// File: tb/tb_dac_wave_gen.sv
// tb_dac_wave_gen: randomized and directed checking of dac_wave_gen against a behavioural model
module tb_dac_wave_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_mode = 2'd0;
    logic [15:0] cfg_ftw = 16'd0;
    logic [4:0]  dac_code;
    logic        wrap;

    int n_chk = 0;
    int n_fail = 0;
    bit check_on = 1'b0;

    logic [15:0] m_acc, m_ftw, m_sftw;
    logic [1:0]  m_mode, m_smode;
    bit          m_run, m_pend;
    logic [4:0]  m_dac;
    logic        m_wrap;

    dac_wave_gen #(.ACC_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode), .cfg_ftw(cfg_ftw), .dac_code(dac_code), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waveform shapes straight from their mathematical definitions.
    function automatic logic [4:0] wave(input logic [1:0] md, input logic [15:0] a);
        int  k = int'(a) / 2048;
        int  ph = int'(a) / 1024;
        real v;
        if (md == 2'd0) return 5'(k);
        if (md == 2'd1) return 5'(ph < 32 ? ph : 63 - ph);
        if (md == 2'd2) return a >= 16'h8000 ? 5'd31 : 5'd0;
        v = $floor(16.0 + 15.5 * $sin(2.0 * 3.14159265358979 * k / 32.0));
        if (v < 0.0) v = 0.0;
        if (v > 31.0) v = 31.0;
        return 5'(int'(v));
    endfunction

    // Behavioural model: advances on each clock with the inputs seen at that edge.
    always @(posedge clk) begin
        int  s;
        bit  h;
        if (rst) begin
            m_acc = 0; m_ftw = 0; m_sftw = 0; m_mode = 0; m_smode = 0;
            m_run = 0; m_pend = 0; m_dac = 0; m_wrap = 0;
        end else begin
            h = cfg_valid && !m_pend;
            if (!m_run || !en) begin
                m_dac = 0; m_wrap = 0; m_acc = 0;
                if (m_pend) begin
                    m_mode = m_smode; m_ftw = m_sftw;
                end else if (h) begin
                    m_mode = cfg_mode; m_ftw = cfg_ftw;
                end
                m_pend = 0;
                m_run = en;
            end else begin
                m_dac = wave(m_mode, m_acc);
                s = int'(m_acc) + int'(m_ftw);
                m_wrap = s >= 65536;
                m_acc = 16'(s % 65536);
                if (m_pend && m_wrap) begin
                    m_mode = m_smode; m_ftw = m_sftw; m_pend = 0;
                end else if (h) begin
                    m_smode = cfg_mode; m_sftw = cfg_ftw; m_pend = 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (check_on) begin
            chk("dac_code", dac_code, m_dac);
            chk("wrap", wrap, m_wrap);
            chk("cfg_ready", cfg_ready, !rst && !m_pend);
        end
    end

    initial begin
        logic [4:0] d1, d2;
        logic [4:0] codes [64];
        bit found;

        chk("model_sine_k0", wave(3, 16'd0), 16);
        chk("model_sine_k8", wave(3, 16'd16384), 31);
        chk("model_sine_k16", wave(3, 16'd32768), 16);
        chk("model_sine_k24", wave(3, 16'd49152), 0);
        chk("model_tri_top", wave(1, 16'd32768), 31);
        chk("model_sq_hi", wave(2, 16'h8000), 31);
        chk("model_sq_lo", wave(2, 16'h7FFF), 0);

        step();
        check_on = 1'b1;
        chk("ready_in_reset", cfg_ready, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", cfg_ready, 1);
        chk("dac_after_reset", dac_code, 0);

        cfg_valid = 1'b1; cfg_mode = 2'd0; cfg_ftw = 16'd2048;
        step();
        cfg_valid = 1'b0; en = 1'b1;
        step();
        for (int i = 0; i < 41; i++) begin
            step();
            chk("saw_code", dac_code, i % 32);
            chk("saw_wrap", wrap, int'((i + 1) % 32 == 0));
        end

        cfg_valid = 1'b1; cfg_ftw = 16'd4096;
        step();
        chk("pend_ready", cfg_ready, 0);
        cfg_ftw = 16'd8192;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            step();
            found = wrap;
        end
        cfg_valid = 1'b0;
        chk("pend_wrap_seen", found, 1);
        step();
        step();
        d1 = dac_code;
        step();
        d2 = dac_code;
        chk("double_step", 5'(d2 - d1), 2);

        cfg_valid = 1'b1; cfg_mode = 2'd3; cfg_ftw = 16'd2048;
        step();
        cfg_valid = 1'b0;
        chk("sine_pend_ready", cfg_ready, 0);
        en = 1'b0;
        step();
        chk("drop_en_dac", dac_code, 0);
        chk("drop_en_ready", cfg_ready, 1);
        en = 1'b1;
        step();
        step();
        chk("sine_k0", dac_code, 16);
        for (int j = 1; j <= 24; j++) begin
            step();
            if (j == 8) chk("sine_k8", dac_code, 31);
            if (j == 16) chk("sine_k16", dac_code, 16);
            if (j == 24) chk("sine_k24", dac_code, 0);
        end

        en = 1'b0;
        step();
        cfg_valid = 1'b1; cfg_mode = 2'd1; cfg_ftw = 16'd1024;
        step();
        cfg_valid = 1'b0; en = 1'b1;
        step();
        for (int i = 0; i < 64; i++) begin
            step();
            codes[i] = dac_code;
        end
        chk("tri_0", codes[0], 0);
        chk("tri_31", codes[31], 31);
        chk("tri_32", codes[32], 31);
        chk("tri_63", codes[63], 0);

        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            step();
            found = dac_code == 5'd20;
        end
        chk("reach_code20", found, 1);
        rst = 1'b1;
        step();
        chk("rst_dac", dac_code, 0);
        chk("rst_wrap", wrap, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("rst_ftw0_dac", dac_code, 0);

        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 199) == 0;
            en = $urandom_range(0, 19) != 0;
            cfg_valid = $urandom_range(0, 7) == 0;
            cfg_mode = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0: cfg_ftw = 16'd0;
                1: cfg_ftw = 16'($urandom_range(1, 4095));
                2: cfg_ftw = 16'd2048;
                3: cfg_ftw = 16'($urandom);
                default: cfg_ftw = 16'hFFFF;
            endcase
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
